// File: rtl/data_memory_responder_pkg.sv
// ============================================================================
// Module  : data_memory_responder_pkg
// Brief   : Shared MMIO constants and read-source select encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package data_memory_responder_pkg;

    localparam logic [3:0]  MMIO_BASE_NIBBLE = 4'hF;
    localparam logic [31:0] MMIO_CYCLE_ADDR  = 32'hF000_0000;
    localparam logic [31:0] MMIO_GPIO_ADDR   = 32'hF000_0004;

    typedef enum logic [1:0] {
        SEL_RAM   = 2'd0,
        SEL_CYCLE = 2'd1,
        SEL_GPIO  = 2'd2,
        SEL_ERR   = 2'd3
    } dmem_sel_t;

endpackage

`default_nettype wire

// File: rtl/data_memory_responder_if.sv
// ============================================================================
// Module  : data_memory_face
// Brief   : Data-memory bus between a CPU (master) and the memory (mem).
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface data_memory_face;

    logic [3:0]  MemWriteEnable;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;

    modport mem (
        input  MemWriteEnable,
        input  Addr_out,
        input  Data_out,
        output Data_in
    );

    modport master (
        output MemWriteEnable,
        output Addr_out,
        output Data_out,
        input  Data_in
    );

endinterface

`default_nettype wire

// File: rtl/data_memory_responder_bram.sv
// ============================================================================
// Module  : dmem_bram
// Brief   : Byte-enable synchronous RAM, write-first registered read port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dmem_bram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read data is the post-write merge so a same-cycle write is visible.
    always_comb begin
        rdata_d = mem_q[addr];
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                rdata_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_responder.sv
// ============================================================================
// Module  : data_memory_responder
// Brief   : Data memory with RAM, optional MMIO (cycle counter, GPIO) and a
//           sticky out-of-range flag. MMIO present when DMEM_MMIO_EN defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    data_memory_face.mem      bus,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              addr_err
);

    localparam int AW = $clog2(DEPTH);

    dmem_sel_t   sel_d;
    dmem_sel_t   sel_q;
    logic        err_d;
    logic        err_q;
    logic        in_ram;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    assign in_ram = (bus.Addr_out[31:AW+2] == '0);

    always_comb begin
        sel_d = SEL_ERR;
        if (in_ram) begin
            sel_d = SEL_RAM;
        end
`ifdef DMEM_MMIO_EN
        else if (bus.Addr_out[31:28] == MMIO_BASE_NIBBLE &&
                 bus.Addr_out[27:2] == MMIO_CYCLE_ADDR[27:2]) begin
            sel_d = SEL_CYCLE;
        end
        else if (bus.Addr_out[31:28] == MMIO_BASE_NIBBLE &&
                 bus.Addr_out[27:2] == MMIO_GPIO_ADDR[27:2]) begin
            sel_d = SEL_GPIO;
        end
`endif
        err_d  = err_q | (sel_d == SEL_ERR);
        ram_we = (rstn && sel_d == SEL_RAM) ? bus.MemWriteEnable : 4'b0000;
    end

    // Reset parks the select on SEL_ERR so Data_in reads 0 until a real access.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_q <= SEL_ERR;
            err_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            err_q <= err_d;
        end
    end

    assign addr_err = err_q;

    dmem_bram #(
        .DEPTH (DEPTH)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.Addr_out[AW+1:2]),
        .wdata (bus.Data_out),
        .rdata (ram_rdata)
    );

`ifdef DMEM_MMIO_EN
    logic [31:0]       cycle_d;
    logic [31:0]       cycle_q;
    logic [GPIO_W-1:0] gpio_d;
    logic [GPIO_W-1:0] gpio_q;
    logic [31:0]       mmio_rdata_d;
    logic [31:0]       mmio_rdata_q;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        gpio_d  = gpio_q;
        if (sel_d == SEL_GPIO) begin
            for (int b = 0; b < GPIO_W; b++) begin
                if (bus.MemWriteEnable[b/8]) begin
                    gpio_d[b] = bus.Data_out[b];
                end
            end
        end
        mmio_rdata_d = '0;
        case (sel_d)
            SEL_CYCLE: mmio_rdata_d = cycle_q;
            SEL_GPIO:  mmio_rdata_d[GPIO_W-1:0] = gpio_d;
            default:   mmio_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_q      <= '0;
            gpio_q       <= '0;
            mmio_rdata_q <= '0;
        end else begin
            cycle_q      <= cycle_d;
            gpio_q       <= gpio_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign gpio_out = gpio_q;

    always_comb begin
        case (sel_q)
            SEL_RAM:            bus.Data_in = ram_rdata;
            SEL_CYCLE, SEL_GPIO: bus.Data_in = mmio_rdata_q;
            default:            bus.Data_in = '0;
        endcase
    end
`else
    assign gpio_out    = '0;
    assign bus.Data_in = (sel_q == SEL_RAM) ? ram_rdata : 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module  : tb_data_memory_responder
// Brief   : Randomised self-checking bench against a word/array reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

    localparam int DEPTH  = 1024;
    localparam int GPIO_W = 16;
    localparam logic [31:0] GMASK = (GPIO_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << GPIO_W) - 32'd1);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [GPIO_W-1:0] gpio_out;
    logic              addr_err;

    data_memory_face bus_if ();

    data_memory_responder #(
        .DEPTH  (DEPTH),
        .GPIO_W (GPIO_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus_if.mem),
        .gpio_out (gpio_out),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_data;
    logic [31:0] m_gpio;
    logic [31:0] m_cyc;
    logic        m_err;

    // One bus cycle: drive at negedge, update the model, return just after posedge.
    task automatic drive(input logic rst_n, input logic [3:0] mwe,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        logic [31:0] idx;
        @(negedge clk);
        rstn                  = rst_n;
        bus_if.MemWriteEnable = mwe;
        bus_if.Addr_out       = addr;
        bus_if.Data_out       = wd;
        idx = addr >> 2;
        if (!rst_n) begin
            m_data = '0;
            m_err  = 1'b0;
            m_gpio = '0;
            m_cyc  = '0;
        end else begin
            if (idx < DEPTH) begin
                w = m_mem[idx];
                for (int i = 0; i < 4; i++) if (mwe[i]) w[8*i +: 8] = wd[8*i +: 8];
                m_mem[idx] = w;
                m_data = w;
`ifdef DMEM_MMIO_EN
            end else if (idx == (32'hF000_0000 >> 2)) begin
                m_data = m_cyc;
            end else if (idx == (32'hF000_0004 >> 2)) begin
                w = m_gpio;
                for (int i = 0; i < 4; i++) if (mwe[i]) w[8*i +: 8] = wd[8*i +: 8];
                m_gpio = w & GMASK;
                m_data = m_gpio;
`endif
            end else begin
                m_data = '0;
                m_err  = 1'b1;
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ram_addr();
        logic [31:0] a;
        a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    task automatic test_reset();
        drive(1'b0, 4'hF, 32'h10, $urandom);
        drive(1'b0, 4'hF, 32'h14, $urandom);
        checks++;
        if (bus_if.Data_in !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %h expected %h", bus_if.Data_in, 32'd0);
        end
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", addr_err);
        end
        checks++;
        if (gpio_out !== '0) begin
            errors++; $display("FAIL reset_gpio: got %h expected 0", gpio_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'hF, 32'(i) << 2, $urandom);
            checks++;
            if (bus_if.Data_in !== m_data) begin
                errors++; $display("FAIL fill[%0d]: got %h expected %h", i, bus_if.Data_in, m_data);
            end
        end
    endtask

    task automatic test_byte_lane();
        drive(1'b1, 4'hF, 32'h10, 32'h1122_3344);
        drive(1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD);
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'h11BB_33DD) begin
            errors++; $display("FAIL byte_lane: got %h expected %h", bus_if.Data_in, 32'h11BB_33DD);
        end
        for (int n = 0; n < 80; n++) begin
            drive(1'b1, 4'($urandom), rand_ram_addr(), $urandom);
            checks++;
            if (bus_if.Data_in !== m_data) begin
                errors++; $display("FAIL lane_rand[%0d]: got %h expected %h", n, bus_if.Data_in, m_data);
            end
        end
    endtask

    task automatic test_write_first_b2b();
        drive(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        checks++;
        if (bus_if.Data_in !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_first: got %h expected %h", bus_if.Data_in, 32'hDEAD_BEEF);
        end
        drive(1'b1, 4'h0, 32'h24, 32'h0);
        checks++;
        if (bus_if.Data_in !== m_mem[9]) begin
            errors++; $display("FAIL b2b_read: got %h expected %h", bus_if.Data_in, m_mem[9]);
        end
    endtask

    task automatic test_random_mix();
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = rand_ram_addr();
`ifdef DMEM_MMIO_EN
            if (r == 8) a = 32'hF000_0000 | 32'($urandom_range(0, 3));
            if (r == 9) a = 32'hF000_0004 | 32'($urandom_range(0, 3));
`endif
            drive(1'b1, (r < 5) ? 4'($urandom) : 4'h0, a, $urandom);
            checks++;
            if (bus_if.Data_in !== m_data || addr_err !== m_err || 32'(gpio_out) !== m_gpio) begin
                errors++;
                $display("FAIL mix[%0d] addr=%h: got data=%h err=%b gpio=%h expected data=%h err=%b gpio=%h",
                         n, a, bus_if.Data_in, addr_err, gpio_out, m_data, m_err, m_gpio);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] word0;
        logic [31:0] a;
        word0 = m_mem[0];
        drive(1'b1, 4'hF, 32'(4 * DEPTH), 32'h5);
        checks++;
        if (bus_if.Data_in !== 32'd0 || addr_err !== 1'b1) begin
            errors++; $display("FAIL oor_write: got data=%h err=%b expected data=0 err=1", bus_if.Data_in, addr_err);
        end
        drive(1'b1, 4'h0, 32'(4 * DEPTH), 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'd0 || addr_err !== 1'b1) begin
            errors++; $display("FAIL oor_read: got data=%h err=%b expected data=0 err=1", bus_if.Data_in, addr_err);
        end
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (bus_if.Data_in !== word0 || addr_err !== 1'b1) begin
            errors++; $display("FAIL oor_word0: got data=%h err=%b expected data=%h err=1", bus_if.Data_in, addr_err, word0);
        end
        for (int n = 0; n < 20; n++) begin
            a = $urandom_range(4 * DEPTH, 32'hEFFF_FFFF);
            drive(1'b1, 4'hF, a, $urandom);
            drive(1'b1, 4'h0, rand_ram_addr(), 32'h0);
            checks++;
            if (bus_if.Data_in !== m_data || addr_err !== 1'b1) begin
                errors++; $display("FAIL oor_rand[%0d]: got data=%h err=%b expected data=%h err=1", n, bus_if.Data_in, addr_err, m_data);
            end
        end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [31:0] c0;
        drive(1'b1, 4'b0011, 32'hF000_0004, 32'h0000_ABCD);
        checks++;
        if (gpio_out !== GPIO_W'(32'hABCD)) begin
            errors++; $display("FAIL gpio_write: got %h expected %h", gpio_out, 32'hABCD);
        end
        drive(1'b1, 4'hF, 32'hF000_0004, 32'hFFFF_1234);
        checks++;
        if (bus_if.Data_in !== m_data || 32'(gpio_out) !== m_gpio) begin
            errors++; $display("FAIL gpio_trunc: got data=%h gpio=%h expected %h", bus_if.Data_in, gpio_out, m_gpio);
        end
        drive(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        c0 = bus_if.Data_in;
        for (int n = 0; n < 4; n++) drive(1'b1, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'hF, 32'hF000_0000, $urandom);
        checks++;
        if (bus_if.Data_in - c0 !== 32'd5 || bus_if.Data_in !== m_data) begin
            errors++; $display("FAIL cycle_delta: got %h expected %h", bus_if.Data_in, m_data);
        end
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        drive(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        drive(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'd0) begin
            errors++; $display("FAIL cycle_wrap: got %h expected %h", bus_if.Data_in, 32'd0);
        end
    endtask
`else
    task automatic test_no_mmio();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'd0 || addr_err !== 1'b1 || gpio_out !== '0) begin
            errors++; $display("FAIL no_mmio_cycle: got data=%h err=%b gpio=%h expected 0/1/0", bus_if.Data_in, addr_err, gpio_out);
        end
        drive(1'b1, 4'hF, 32'hF000_0004, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, 32'hF000_0004, 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'd0 || gpio_out !== '0) begin
            errors++; $display("FAIL no_mmio_gpio: got data=%h gpio=%h expected 0/0", bus_if.Data_in, gpio_out);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        drive(1'b0, 4'hF, 32'h10, 32'h0BAD_0BAD);
        checks++;
        if (bus_if.Data_in !== 32'd0 || addr_err !== 1'b0 || gpio_out !== '0) begin
            errors++; $display("FAIL midreset: got data=%h err=%b gpio=%h expected 0/0/0", bus_if.Data_in, addr_err, gpio_out);
        end
`ifdef DMEM_MMIO_EN
        drive(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checks++;
        if (bus_if.Data_in !== 32'd0) begin
            errors++; $display("FAIL midreset_cycle: got %h expected 0", bus_if.Data_in);
        end
`endif
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        checks++;
        if (bus_if.Data_in !== m_mem[4] || addr_err !== 1'b0) begin
            errors++; $display("FAIL midreset_ram: got data=%h err=%b expected %h/0", bus_if.Data_in, addr_err, m_mem[4]);
        end
    endtask

    initial begin
        bus_if.MemWriteEnable = 4'h0;
        bus_if.Addr_out       = 32'h0;
        bus_if.Data_out       = 32'h0;
        m_data = '0; m_gpio = '0; m_cyc = '0; m_err = 1'b0;
        test_reset();
        test_fill();
        test_byte_lane();
        test_write_first_b2b();
        test_random_mix();
        test_out_of_range();
`ifdef DMEM_MMIO_EN
        test_mmio();
`else
        test_no_mmio();
`endif
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning number of 32-bit RAM words (power of two, at most 2^26).
REQ-002 The block SHALL have parameter GPIO_W, default 16, meaning width of the MMIO output register (1..32).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port bus, data_memory_face.mem modport, with the following fields:
- MemWriteEnable [3:0] in: byte-lane write strobes.
- Addr_out [31:0] in: byte address, 4-byte aligned.
- Data_out [31:0] in: write data.
- Data_in [31:0] out: read data.
REQ-006 The block SHALL have port gpio_out, output, GPIO_W bits: MMIO output register value.
REQ-007 The block SHALL have port addr_err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-008 Word index SHALL be Addr_out[log2(DEPTH)+1:2]; Addr_out[1:0] SHALL be ignored.
REQ-009 RAM region SHALL be addresses 0 .. 4*DEPTH-1; any other address outside the MMIO region (REQ-014) is out-of-range.
REQ-010 On each rising edge with any MemWriteEnable bit set and a RAM address, lane i (bits 8i+7:8i) SHALL be written from Data_out only where MemWriteEnable[i]=1; other lanes SHALL be unchanged.
REQ-011 Reads SHALL be registered, with 1-cycle latency: Data_in during cycle n+1 SHALL equal the word at the cycle-n address.
REQ-012 Reads SHALL be write-first: when cycle n both writes and addresses word W, Data_in in cycle n+1 SHALL be the merged post-write word.
REQ-013 Out-of-range accesses SHALL:
- ignore writes;
- produce Data_in = 0 in the next cycle;
- set addr_err to 1 from the next cycle until reset.
REQ-014 MMIO region SHALL be Addr_out[31:28] = 4'hF, decoded as follows:
- 0xF000_0000: read-only free-running cycle counter.
- 0xF000_0004: GPIO register; byte lanes writable per MemWriteEnable; reads return the register zero-extended to 32 bits.
- Any other 0xFxxx_xxxx address: out-of-range.
REQ-015 The cycle counter SHALL increment by 1 every cycle rstn=1 and wrap 0xFFFF_FFFF -> 0; writes to it SHALL be ignored with no error.
REQ-016 A counter read SHALL return the counter value sampled at the addressing edge (value before that edge's increment).
REQ-017 gpio_out SHALL update the cycle after the GPIO write edge; GPIO bits at or above GPIO_W SHALL be discarded on write and read as 0.
REQ-018 Back-to-back accesses on consecutive cycles SHALL be supported with no stall; the block SHALL have no back-pressure.

Reset
REQ-019 While rstn=0 at a rising edge, the following SHALL be set: Data_in=0, addr_err=0, cycle counter=0, GPIO register=0 (gpio_out=0).
REQ-020 RAM contents SHALL NOT be reset; a write coinciding with an rstn=0 edge SHALL be discarded (RAM, GPIO).
REQ-021 Reset mid-stream SHALL cancel any pending read result; the first Data_in after release SHALL reflect the first address presented with rstn=1.

Configuration
REQ-022 Macro DMEM_MMIO_EN SHALL control the MMIO region:
- Defined: the MMIO region (REQ-014..017) SHALL be present.
- Undefined: counter and GPIO logic SHALL be absent, 0xFxxx_xxxx addresses SHALL be out-of-range (REQ-013), and gpio_out SHALL be constant 0.

Structure
REQ-023 The shared header/package SHALL hold the following constants:
- MMIO_BASE_NIBBLE (4'hF).
- MMIO_CYCLE_ADDR (32'hF000_0000).
- MMIO_GPIO_ADDR (32'hF000_0004).
- A typedef enum dmem_sel_t {SEL_RAM, SEL_CYCLE, SEL_GPIO, SEL_ERR} for the registered read-source select.
REQ-024 The RAM array SHALL be a sub-module dmem_bram (byte-enable synchronous write-first RAM, parameter DEPTH).
REQ-025 Decode, the read mux, the counter, GPIO and the error flag SHALL reside in data_memory_responder.

Verification
REQ-026 Byte-lane write: write 0x11223344 at 0x10 with MWE=4'hF, then 0xAABBCCDD with MWE=4'b0101 -> read 0x10 returns 0x11BB33DD one cycle later.
REQ-027 Write-first: in one cycle, write 0xDEADBEEF MWE=4'hF at 0x20 while addressing 0x20 -> Data_in=0xDEADBEEF next cycle; a back-to-back read of 0x24 returns prior contents with no bubble.
REQ-028 Out-of-range: DEPTH=1024, write 0x5 to 0x1000 then read 0x1000 -> Data_in=0, addr_err=1 and stays 1; RAM word 0 unchanged.
REQ-029 MMIO (macro defined): write 0x0000ABCD MWE=4'b0011 to 0xF000_0004 -> gpio_out=0xABCD next cycle; two counter reads 5 cycles apart differ by 5; with the counter forced to 0xFFFF_FFFF, the next read shows 0.
REQ-030 Macro undefined: read 0xF000_0000 -> Data_in=0, addr_err=1, gpio_out=0.
REQ-031 Reset mid-stream: issue read of 0x10, assert rstn=0 for 1 cycle -> Data_in=0, addr_err=0, gpio_out=0, counter=0; RAM word 0x10 retains its data on the next read.
